dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: the execute-stage load/store path.
  - port 1: the test/loader path that preloads and dumps memory.
- Grants one access per cycle, drives the memory read/write/address/datain lines, and routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the execute stage and the data memory instance.

Parameters:
- ADDR_W, 32, address width; matches the data memory address port.
- DATA_W, 32, data word width.
- MAX_CONSEC, 4, maximum consecutive port-0 grants while port 1 waits (starvation guard); legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_read  out  1  to data memory read.
- mem_write  out  1  to data memory write.
- mem_address  out  ADDR_W  to data memory address.
- mem_datain  out  DATA_W  to data memory datain.
- mem_dataout  in  DATA_W  from data memory dataout; updated at the edge that samples mem_read.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Handshake: a transfer occurs in a cycle where reqN_valid=1 and reqN_ready=1.
  - reqN_ready is combinational from the valids and arbiter state.
  - Requesters must not make valid depend on ready.
  - Requesters must hold valid, write, addr and wdata stable until accepted.
- Grant (combinational, at most one ready per cycle):
  - Only one valid: that port is granted.
  - Both valid: port 0 wins unless consec_cnt == MAX_CONSEC. In that case port 1 wins.
  - Neither valid: no grant; mem_read=mem_write=0.
- consec_cnt (4-bit):
  - Increments when port 0 is granted while req1_valid=1.
  - Clears on any port-1 grant and on any cycle with req1_valid=0.
  - Saturates at MAX_CONSEC.
- Memory drive (combinational from the granted port):
  - mem_address = addr; mem_datain = wdata.
  - mem_write = write; mem_read = ~write.
  - With no grant, address and datain are driven to 0.
- Read response:
  - On an accepted read, a registered rsp_pending bit and rsp_port are set at that edge.
  - In the following cycle rspN_valid=1 for the recorded port, and rspN_rdata = mem_dataout (passthrough).
  - The other port's rdata is 0.
  - Exactly one cycle of rspN_valid per accepted read; there is no backpressure on responses.
- Throughput: a new request may be accepted in the same cycle a prior response is presented (back-to-back reads give one response per cycle).
- Writes: complete at the accepting edge; no response.
- Read-after-write to the same address on consecutive cycles returns the new data (memory ordering; no forwarding needed).
- Reset values:
  - reqN_ready=0, rspN_valid=0, rspN_rdata=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_datain=0.
  - consec_cnt=0, rsp_pending=0.
- Reset asserted mid-operation:
  - Any pending response is dropped (rsp_valid low immediately, asynchronously).
  - No grant while reset is high.
- Address range: no range checking; out-of-range addresses pass to memory unchanged.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, port index constants PORT_EXE=0 and PORT_LDR=1, and the response-tag typedef (pending bit plus port bit).
- One sub-module is natural: dmem_arb_grant. It is the combinational two-way priority select with starvation override; the counter stays in the top level.

Test Plan:
- Reset, then a single port-0 read at addr 2 (memory preloaded with 30): req0_ready=1 that cycle; next cycle rsp0_valid=1 and rsp0_rdata=30; rsp1_valid stays 0.
- Port-1 write of 0xDEAD_BEEF to addr 7, then port-1 read of addr 7 the next cycle: rsp1_rdata=0xDEADBEEF one cycle after the read is accepted.
- Both ports valid continuously with MAX_CONSEC=4: grant sequence is 0,0,0,0,1,0,0,0,0,1…; every accepted read returns on its own port with the correct data.
- Back-to-back port-0 reads of addrs 1,3,5: rsp0_valid high for 3 consecutive cycles with data 4,19,10.
- Assert reset the cycle after a port-1 read is accepted: rsp1_valid never asserts; all outputs are 0 during reset; the first post-reset request is granted normally.
- Same-cycle port-0 write of 99 to addr 4 and port-1 read of addr 4: port 0 is granted, port 1 is stalled (ready=0), and port 1's read of addr 4 then returns 99.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: width defaults, port indices
// and the tag recording which port is owed a read response.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_EXE = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic pending;
        logic port;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Two-way priority select: port 0 (execute) wins ties unless the starvation
// guard says port 1 (loader) has waited long enough.
module dmem_arb_grant
    import dmem_arbiter_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic starve_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic sel_o
);

    always_comb begin
        grant1_o = valid1_i & (~valid0_i | starve_i);
        grant0_o = valid0_i & ~grant1_o;
        sel_o    = grant1_o ? PORT_LDR : PORT_EXE;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the execute path (port 0) and the
// loader path (port 1); routes one-cycle-latency read data back to the reader.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

    logic     [3:0] consec_q, consec_d;
    rsp_tag_t       tag_q, tag_d;
    logic           v0, v1, grant0, grant1, sel;

    // Requests are masked while reset is high so nothing reaches memory.
    assign v0 = req0_valid & ~reset;
    assign v1 = req1_valid & ~reset;

    dmem_arb_grant u_grant (
        .valid0_i (v0),
        .valid1_i (v1),
        .starve_i (consec_q == MAX_C),
        .grant0_o (grant0),
        .grant1_o (grant1),
        .sel_o    (sel)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_datain  = '0;
        if (grant0) begin
            mem_read    = ~req0_write;
            mem_write   = req0_write;
            mem_address = req0_addr;
            mem_datain  = req0_wdata;
        end else if (grant1) begin
            mem_read    = ~req1_write;
            mem_write   = req1_write;
            mem_address = req1_addr;
            mem_datain  = req1_wdata;
        end
    end

    // Counts port-0 wins only while port 1 is actually waiting.
    always_comb begin
        consec_d = consec_q;
        if (!v1 || grant1) begin
            consec_d = 4'd0;
        end else if (grant0 && consec_q != MAX_C) begin
            consec_d = consec_q + 4'd1;
        end
    end

    always_comb begin
        tag_d.pending = (grant0 & ~req0_write) | (grant1 & ~req1_write);
        tag_d.port    = sel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            consec_q <= 4'd0;
            tag_q    <= '0;
        end else begin
            consec_q <= consec_d;
            tag_q    <= tag_d;
        end
    end

    assign rsp0_valid = tag_q.pending & (tag_q.port == PORT_EXE);
    assign rsp1_valid = tag_q.pending & (tag_q.port == PORT_LDR);
    assign rsp0_rdata = rsp0_valid ? mem_dataout : '0;
    assign rsp1_rdata = rsp1_valid ? mem_dataout : '0;

endmodule
